// File: rtl/hazard_unit.sv
// Hazard detector for the ID stage: EXE/MEM destination shadows plus a multiply busy counter.
// Define HAZARD_FORWARDING_EN to stall only on load-use/multiply and emit forwarding selects.
module hazard_unit #(
    parameter int REG_ADDR_LEN = 5,
    parameter int MULT_LAT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_src2_used,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    id_wb_en,
    input  logic                    id_mem_r_en,
    input  logic                    id_is_mult,
    output logic                    hazard_detected,
    output logic                    exe_freeze,
    output logic [1:0]              fwd_src1,
    output logic [1:0]              fwd_src2,
    output logic [15:0]             stall_count
);
    localparam int CNT_W = $clog2(MULT_LAT) + 1;

    typedef struct packed {
        logic                    valid;
        logic                    wb_en;
        logic                    mem_r_en;
        logic [REG_ADDR_LEN-1:0] dest;
    } exe_shadow_t;

    typedef struct packed {
        logic                    valid;
        logic                    wb_en;
        logic [REG_ADDR_LEN-1:0] dest;
    } mem_shadow_t;

    exe_shadow_t      exe_sh;
    mem_shadow_t      mem_sh;
    logic [CNT_W-1:0] mult_cnt;

    logic mult_busy;
    logic exe_hit1, exe_hit2, mem_hit1, mem_hit2;
    logic raw_stall;
    logic [1:0] fwd1_raw, fwd2_raw;

    assign mult_busy = (mult_cnt != '0);

    // A producer of r0 never creates a dependence; src2 only counts when it is read.
    always_comb begin
        exe_hit1 = id_valid && exe_sh.valid && exe_sh.wb_en && (exe_sh.dest != '0)
                   && (exe_sh.dest == id_src1);
        exe_hit2 = id_valid && id_src2_used && exe_sh.valid && exe_sh.wb_en
                   && (exe_sh.dest != '0) && (exe_sh.dest == id_src2);
        mem_hit1 = id_valid && mem_sh.valid && mem_sh.wb_en && (mem_sh.dest != '0)
                   && (mem_sh.dest == id_src1);
        mem_hit2 = id_valid && id_src2_used && mem_sh.valid && mem_sh.wb_en
                   && (mem_sh.dest != '0) && (mem_sh.dest == id_src2);
    end

`ifdef HAZARD_FORWARDING_EN
    assign raw_stall = exe_sh.mem_r_en && (exe_hit1 || exe_hit2);

    // EXE holds the younger producer so it wins; a load in EXE has no result to forward yet.
    always_comb begin
        fwd1_raw = 2'b00;
        fwd2_raw = 2'b00;
        if (exe_hit1)      fwd1_raw = exe_sh.mem_r_en ? 2'b00 : 2'b01;
        else if (mem_hit1) fwd1_raw = 2'b10;
        if (exe_hit2)      fwd2_raw = exe_sh.mem_r_en ? 2'b00 : 2'b01;
        else if (mem_hit2) fwd2_raw = 2'b10;
    end
`else
    logic unused_exe_mem_r_en;

    assign raw_stall = exe_hit1 || exe_hit2 || mem_hit1 || mem_hit2;
    assign fwd1_raw  = 2'b00;
    assign fwd2_raw  = 2'b00;
    // Load flag is only consulted when forwarding is built in.
    assign unused_exe_mem_r_en = exe_sh.mem_r_en;
`endif

    assign hazard_detected = !rst && (raw_stall || mult_busy);
    assign exe_freeze      = !rst && mult_busy;
    assign fwd_src1        = rst ? 2'b00 : fwd1_raw;
    assign fwd_src2        = rst ? 2'b00 : fwd2_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_sh      <= '0;
            mem_sh      <= '0;
            mult_cnt    <= '0;
            stall_count <= '0;
        end else begin
            // Freeze holds the multiply in EXE and drains a bubble into MEM.
            if (exe_freeze) begin
                mem_sh <= '0;
            end else begin
                mem_sh.valid <= exe_sh.valid;
                mem_sh.wb_en <= exe_sh.wb_en;
                mem_sh.dest  <= exe_sh.dest;
                if (hazard_detected) begin
                    exe_sh <= '0;
                end else begin
                    exe_sh.valid    <= id_valid;
                    exe_sh.wb_en    <= id_wb_en;
                    exe_sh.mem_r_en <= id_mem_r_en;
                    exe_sh.dest     <= id_dest;
                end
            end

            if (!hazard_detected && id_valid && id_is_mult)
                mult_cnt <= CNT_W'(MULT_LAT - 1);
            else if (mult_busy)
                mult_cnt <= mult_cnt - CNT_W'(1);

            if (hazard_detected && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Table-driven bench for hazard_unit; expectations cover both forwarding builds.
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       id_src2_used, id_wb_en, id_mem_r_en, id_is_mult;
    logic       hazard_detected, exe_freeze;
    logic [1:0] fwd_src1, fwd_src2;
    logic [15:0] stall_count;

    hazard_unit #(.REG_ADDR_LEN(5), .MULT_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_is_mult(id_is_mult), .hazard_detected(hazard_detected),
        .exe_freeze(exe_freeze), .fwd_src1(fwd_src1), .fwd_src2(fwd_src2),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       r, v;
        logic [4:0] s1, s2;
        logic       s2u;
        logic [4:0] d;
        logic       wb, mr, mul;
        logic       haz, frz;
        logic [1:0] f1, f2;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_sc = 16'd0;

    task automatic add(input string nm, input int r, input int v, input int s1, input int s2,
                       input int s2u, input int d, input int wb, input int mr, input int mul,
                       input int haz, input int frz, input int f1, input int f2);
        vec_t t;
        t.name = nm; t.r = r[0]; t.v = v[0];
        t.s1 = s1[4:0]; t.s2 = s2[4:0]; t.s2u = s2u[0]; t.d = d[4:0];
        t.wb = wb[0]; t.mr = mr[0]; t.mul = mul[0];
        t.haz = haz[0]; t.frz = frz[0]; t.f1 = f1[1:0]; t.f2 = f2[1:0];
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
        end
    endtask

    task automatic bub(input string nm);
        add(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_src2_used = 1'b0;
        id_dest = '0; id_wb_en = 1'b0; id_mem_r_en = 1'b0; id_is_mult = 1'b0;

        // Reset with a live producer in ID; nothing may be captured or reported.
        add("rst1", 1, 1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        add("rst2", 1, 1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        bub("post_rst");
`ifdef HAZARD_FORWARDING_EN
        add("add_r3",     0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        add("sub_fwd",    0, 1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0);
        bub("bub_a");
        add("lw_r5",      0, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        add("lu_stall",   0, 1, 7, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0);
        add("lu_fwd",     0, 1, 7, 5, 1, 6, 1, 0, 0, 0, 0, 0, 2);
        bub("bub_b");
        add("add_r2",     0, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        add("addi_r2",    0, 1, 2, 9, 0, 2, 1, 0, 0, 0, 0, 1, 0);
        add("rd_r2_both", 0, 1, 2, 2, 1, 14, 1, 0, 0, 0, 0, 1, 1);
        add("rd_r2_mem",  0, 1, 2, 0, 0, 15, 1, 0, 0, 0, 0, 2, 0);
        add("wr_r0",      0, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add("rd_r0_exe",  0, 1, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        add("rd_r0_mem",  0, 1, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        add("inv_id",     0, 0, 10, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bub("bub_c");
        add("mult",       0, 1, 1, 2, 1, 11, 1, 0, 1, 0, 0, 0, 0);
        add("mbusy1",     0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 1, 1, 0);
        add("mbusy2",     0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 1, 1, 0);
        add("mbusy3",     0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 1, 1, 0);
        add("m_fwd",      0, 1, 11, 0, 1, 12, 1, 0, 0, 0, 0, 1, 0);
        bub("bub_d");
`else
        add("add_r3",     0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        add("sub_exe",    0, 1, 3, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0);
        add("sub_mem",    0, 1, 3, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0);
        add("sub_go",     0, 1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        bub("bub_a");
        add("lw_r5",      0, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        add("use_exe",    0, 1, 7, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0);
        add("use_mem",    0, 1, 7, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0);
        add("use_go",     0, 1, 7, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        add("s2_unused",  0, 1, 1, 6, 0, 8, 1, 0, 0, 0, 0, 0, 0);
        add("wr_r0",      0, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        add("rd_r0_exe",  0, 1, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        add("rd_r0_mem",  0, 1, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        add("inv_id",     0, 0, 10, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bub("bub_c");
        add("mult",       0, 1, 1, 2, 1, 11, 1, 0, 1, 0, 0, 0, 0);
        add("mbusy1",     0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 1, 0, 0);
        add("mbusy2",     0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 1, 0, 0);
        add("mbusy3",     0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 1, 0, 0);
        add("m_raw_exe",  0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 0, 0, 0);
        add("m_raw_mem",  0, 1, 11, 0, 1, 12, 1, 0, 0, 1, 0, 0, 0);
        add("m_go",       0, 1, 11, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0);
        bub("bub_d");
`endif
        // Reset lands on the second busy cycle of a fresh multiply.
        add("mult2",      0, 1, 1, 2, 1, 13, 1, 0, 1, 0, 0, 0, 0);
        add("m2_busy",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        add("m2_rst",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bub("m2_after");
        bub("m2_after2");

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst = vecs[i].r; id_valid = vecs[i].v; id_src1 = vecs[i].s1; id_src2 = vecs[i].s2;
            id_src2_used = vecs[i].s2u; id_dest = vecs[i].d; id_wb_en = vecs[i].wb;
            id_mem_r_en = vecs[i].mr; id_is_mult = vecs[i].mul;
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk({e.name, ".hazard"}, i, {15'd0, hazard_detected}, {15'd0, e.haz});
            chk({e.name, ".freeze"}, i, {15'd0, exe_freeze}, {15'd0, e.frz});
            chk({e.name, ".fwd1"}, i, {14'd0, fwd_src1}, {14'd0, e.f1});
            chk({e.name, ".fwd2"}, i, {14'd0, fwd_src2}, {14'd0, e.f2});
            if (!e.r) chk({e.name, ".stall_count"}, i, stall_count, exp_sc);
            if (e.r) exp_sc = 16'd0;
            else if (e.haz && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
